// File: rtl/apb_fabric_verif_param_pkg.sv
// rtl/apb_fabric_verif_param_pkg.sv - project-wide APB fabric address/data widths
package apb_fabric_verif_param_pkg;
  localparam int PADDR = 32;
  localparam int PDATA = 32;
endpackage

// File: rtl/apb_fabric_arbiter.sv
// rtl/apb_fabric_arbiter.sv - N-to-1 round-robin APB arbiter with registered
// downstream SETUP/ACCESS sequencing and PREADY timeout.
module apb_fabric_arbiter #(
  parameter int NREQ    = 4,
  parameter int PADDR   = apb_fabric_verif_param_pkg::PADDR,
  parameter int PDATA   = apb_fabric_verif_param_pkg::PDATA,
  parameter int TIMEOUT = 256
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic [NREQ-1:0]         s_psel,
  input  logic [NREQ-1:0]         s_penable,
  input  logic [NREQ-1:0]         s_pwrite,
  input  logic [NREQ*PADDR-1:0]   s_paddr,
  input  logic [NREQ*PDATA-1:0]   s_pwdata,
  output logic [PDATA-1:0]        s_prdata,
  output logic [NREQ-1:0]         s_pready,
  output logic [NREQ-1:0]         s_pslverr,
  output logic                    m_psel,
  output logic                    m_penable,
  output logic                    m_pwrite,
  output logic [PADDR-1:0]        m_paddr,
  output logic [PDATA-1:0]        m_pwdata,
  input  logic [PDATA-1:0]        m_prdata,
  input  logic                    m_pready,
  input  logic                    m_pslverr,
  output logic [$clog2(NREQ)-1:0] grant_id
);
  localparam int IW      = $clog2(NREQ);
  localparam int TW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam int TO_SAT  = (TIMEOUT > 0) ? TIMEOUT : 1;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

  state_t            r_state;
  logic [IW-1:0]     r_rr_ptr;
  logic [IW-1:0]     r_grant;
  logic              r_pwrite;
  logic [PADDR-1:0]  r_paddr;
  logic [PDATA-1:0]  r_pwdata;
  logic              r_m_psel;
  logic              r_m_penable;
  logic [TW-1:0]     r_to_cnt;
  logic [NREQ-1:0]   r_s_pready;
  logic [NREQ-1:0]   r_s_pslverr;
  logic [PDATA-1:0]  r_s_prdata;

  logic              w_found;
  logic [IW-1:0]     w_winner;
  logic [IW:0]       w_scan;
  logic              w_sel_write;
  logic [PADDR-1:0]  w_sel_addr;
  logic [PDATA-1:0]  w_sel_wdata;
  logic [IW-1:0]     w_next_ptr;
  logic [NREQ-1:0]   w_onehot;
  logic              w_to_hit;
  logic              w_unused;

  // Scan starts at rr_ptr and wraps, so the last winner is searched last.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_scan   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_scan = {1'b0, r_rr_ptr} + (IW + 1)'(k);
      if (w_scan >= (IW + 1)'(NREQ)) w_scan = w_scan - (IW + 1)'(NREQ);
      if (!w_found && s_psel[w_scan[IW-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_scan[IW-1:0];
      end
    end
  end

  always_comb begin
    w_sel_write = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IW'(i) == w_winner) begin
        w_sel_write = s_pwrite[i];
        w_sel_addr  = s_paddr[i*PADDR +: PADDR];
        w_sel_wdata = s_pwdata[i*PDATA +: PDATA];
      end
    end
  end

  assign w_next_ptr = (w_winner == IW'(NREQ - 1)) ? '0 : w_winner + IW'(1);
  assign w_onehot   = {{(NREQ-1){1'b0}}, 1'b1} << r_grant;
  assign w_to_hit   = (TIMEOUT != 0) && (r_to_cnt == TW'(TO_LAST));
  assign w_unused   = ^s_penable;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_grant     <= '0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_m_psel    <= 1'b0;
      r_m_penable <= 1'b0;
      r_to_cnt    <= '0;
      r_s_pready  <= '0;
      r_s_pslverr <= '0;
      r_s_prdata  <= '0;
    end else begin
      r_s_pready  <= '0;
      r_s_pslverr <= '0;
      r_s_prdata  <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant  <= w_winner;
            r_rr_ptr <= w_next_ptr;
            r_pwrite <= w_sel_write;
            r_paddr  <= w_sel_addr;
            r_pwdata <= w_sel_wdata;
            r_m_psel <= 1'b1;
            r_state  <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_m_penable <= 1'b1;
          r_to_cnt    <= '0;
          r_state     <= S_ACCESS;
        end
        S_ACCESS: begin
          // m_pready takes priority over a timeout in the same cycle.
          if (m_pready) begin
            r_s_prdata  <= r_pwrite ? '0 : m_prdata;
            r_s_pslverr <= w_onehot & {NREQ{m_pslverr}};
            r_s_pready  <= w_onehot;
            r_m_psel    <= 1'b0;
            r_m_penable <= 1'b0;
            r_state     <= S_RESP;
          end else if (w_to_hit) begin
            r_s_pslverr <= w_onehot;
            r_s_pready  <= w_onehot;
            r_m_psel    <= 1'b0;
            r_m_penable <= 1'b0;
            r_state     <= S_RESP;
          end else if (r_to_cnt != TW'(TO_SAT)) begin
            r_to_cnt <= r_to_cnt + TW'(1);
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign m_psel    = r_m_psel;
  assign m_penable = r_m_penable;
  assign m_pwrite  = r_m_psel & r_pwrite;
  assign m_paddr   = r_m_psel ? r_paddr : '0;
  assign m_pwdata  = r_m_psel ? r_pwdata : '0;
  assign s_pready  = r_s_pready;
  assign s_pslverr = r_s_pslverr;
  assign s_prdata  = r_s_prdata;
  assign grant_id  = r_grant;
endmodule

// File: tb/tb_apb_fabric_arbiter.sv
// tb/tb_apb_fabric_arbiter.sv - scoreboard bench for apb_fabric_arbiter
module tb_apb_fabric_arbiter;
  localparam int NREQ = 4;
  localparam int PADDR = 32;
  localparam int PDATA = 32;
  localparam int TIMEOUT = 8;

  logic PCLK = 1'b0;
  logic PRESETn = 1'b0;
  logic [NREQ-1:0] s_psel = '0;
  logic [NREQ-1:0] s_penable = '0;
  logic [NREQ-1:0] s_pwrite = '0;
  logic [NREQ*PADDR-1:0] s_paddr = '0;
  logic [NREQ*PDATA-1:0] s_pwdata = '0;
  logic [PDATA-1:0] s_prdata;
  logic [NREQ-1:0] s_pready;
  logic [NREQ-1:0] s_pslverr;
  logic m_psel, m_penable, m_pwrite;
  logic [PADDR-1:0] m_paddr;
  logic [PDATA-1:0] m_pwdata;
  logic [PDATA-1:0] m_prdata = '0;
  logic m_pready = 1'b0;
  logic m_pslverr = 1'b0;
  logic [1:0] grant_id;

  apb_fabric_arbiter #(.NREQ(NREQ), .PADDR(PADDR), .PDATA(PDATA), .TIMEOUT(TIMEOUT)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
    .s_paddr(s_paddr), .s_pwdata(s_pwdata),
    .s_prdata(s_prdata), .s_pready(s_pready), .s_pslverr(s_pslverr),
    .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
    .m_paddr(m_paddr), .m_pwdata(m_pwdata),
    .m_prdata(m_prdata), .m_pready(m_pready), .m_pslverr(m_pslverr),
    .grant_id(grant_id)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    int idx;
    logic [PDATA-1:0] data;
    logic err;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail = 0;
  int m_ptr = 0;
  int req_left[NREQ];

  // Slave model configuration and observation
  bit slv_tie1 = 0;
  bit slv_hang = 0;
  bit slv_use_addr = 0;
  bit slv_err = 0;
  int slv_wait = 0;
  logic [PDATA-1:0] slv_rdata = '0;
  int acc_k = 0;
  int acc_total = 0;
  bit stable = 1;
  logic [PADDR-1:0] first_addr = '0;
  logic [PDATA-1:0] first_wdata = '0;
  logic first_write = 1'b0;

  always @(negedge PCLK) begin
    if (m_psel && m_penable) begin
      acc_total++;
      if (acc_k == 0) begin
        first_addr = m_paddr;
        first_wdata = m_pwdata;
        first_write = m_pwrite;
        stable = 1;
      end else if (m_paddr !== first_addr || m_pwdata !== first_wdata || m_pwrite !== first_write) begin
        stable = 0;
      end
      m_pready = slv_tie1 || (!slv_hang && acc_k == slv_wait);
      acc_k++;
    end else begin
      acc_k = 0;
      m_pready = slv_tie1;
    end
    m_prdata = slv_use_addr ? (m_paddr ^ 32'hCAFE0000) : slv_rdata;
    m_pslverr = slv_err;
  end

  // Response monitor: pops the scoreboard on every completion pulse
  always @(negedge PCLK) begin
    exp_t e;
    logic [NREQ-1:0] v;
    if (PRESETn === 1'b1 && s_pready !== '0) begin
      n_checks++;
      if (s_pready !== (4'b0001 << grant_id)) begin
        n_fail++;
        $display("FAIL pready_onehot: s_pready=%b grant_id=%0d", s_pready, grant_id);
      end
      n_checks++;
      if (m_psel !== 1'b0) begin
        n_fail++;
        $display("FAIL resp_msel: m_psel=%b required 0 during response", m_psel);
      end
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_resp: s_pready=%b with nothing expected", s_pready);
      end else begin
        e = sb.pop_front();
        if (int'(grant_id) !== e.idx) begin
          n_fail++;
          $display("FAIL resp_grant: grant_id=%0d required %0d", grant_id, e.idx);
        end
        n_checks++;
        if (s_prdata !== e.data) begin
          n_fail++;
          $display("FAIL resp_rdata: req%0d s_prdata=%h required %h", e.idx, s_prdata, e.data);
        end
        v = e.err ? (4'b0001 << e.idx) : 4'b0000;
        n_checks++;
        if (s_pslverr !== v) begin
          n_fail++;
          $display("FAIL resp_pslverr: s_pslverr=%b required %b", s_pslverr, v);
        end
      end
    end
  end

  task automatic issue(input int i, input logic w, input logic [PADDR-1:0] a,
                       input logic [PDATA-1:0] d, input int n);
    s_psel[i] = 1'b1;
    s_penable[i] = 1'b1;
    s_pwrite[i] = w;
    s_paddr[i*PADDR +: PADDR] = a;
    s_pwdata[i*PDATA +: PDATA] = d;
    req_left[i] = n;
  endtask

  task automatic push_exp(input int i, input logic [PDATA-1:0] d, input logic err);
    exp_t e;
    e.idx = i;
    e.data = d;
    e.err = err;
    sb.push_back(e);
    m_ptr = (i + 1) % NREQ;
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while ((sb.size() != 0 || s_psel != '0) && k < budget) begin
      @(negedge PCLK);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (s_pready[i] && s_psel[i]) begin
          req_left[i]--;
          if (req_left[i] <= 0) begin
            s_psel[i] = 1'b0;
            s_penable[i] = 1'b0;
          end
        end
      end
      k++;
    end
    n_checks++;
    if (sb.size() != 0 || s_psel != '0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d responses pending after %0d cycles", sb.size(), budget);
      sb.delete();
      s_psel = '0;
      s_penable = '0;
    end
    repeat (2) @(negedge PCLK);
  endtask

  task automatic test_reset();
    PRESETn = 1'b0;
    repeat (3) @(negedge PCLK);
    n_checks++;
    if ({m_psel, m_penable, m_pwrite} !== 3'b000 || s_pready !== '0 || s_pslverr !== '0) begin
      n_fail++;
      $display("FAIL reset_ctrl: psel/pen/pwr=%b%b%b s_pready=%b s_pslverr=%b required all 0",
               m_psel, m_penable, m_pwrite, s_pready, s_pslverr);
    end
    n_checks++;
    if (s_prdata !== '0 || m_paddr !== '0 || m_pwdata !== '0 || grant_id !== '0) begin
      n_fail++;
      $display("FAIL reset_data: prdata=%h paddr=%h pwdata=%h grant=%0d required 0",
               s_prdata, m_paddr, m_pwdata, grant_id);
    end
    PRESETn = 1'b1;
    @(posedge PCLK);
    #1;
    n_checks++;
    if (m_psel !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_req: m_psel=%b required 0", m_psel);
    end
    m_ptr = 0;
  endtask

  task automatic test_single_read();
    slv_tie1 = 1;
    slv_use_addr = 0;
    slv_rdata = 32'hDEADBEEF;
    slv_err = 0;
    @(negedge PCLK);
    issue(1, 1'b0, 32'h40, 32'h0, 1);
    push_exp(1, 32'hDEADBEEF, 1'b0);
    @(posedge PCLK);
    #1;
    n_checks++;
    if (m_psel !== 1'b1 || m_penable !== 1'b0 || m_paddr !== 32'h40) begin
      n_fail++;
      $display("FAIL rd_setup: psel=%b penable=%b paddr=%h required 1 0 00000040",
               m_psel, m_penable, m_paddr);
    end
    @(posedge PCLK);
    #1;
    n_checks++;
    if (m_psel !== 1'b1 || m_penable !== 1'b1) begin
      n_fail++;
      $display("FAIL rd_access: psel=%b penable=%b required 1 1", m_psel, m_penable);
    end
    @(posedge PCLK);
    #1;
    n_checks++;
    if (s_pready !== 4'b0010) begin
      n_fail++;
      $display("FAIL rd_latency: s_pready=%b at T+3 required 0010", s_pready);
    end
    wait_drain(20);
    slv_tie1 = 0;
  endtask

  task automatic test_write_waits();
    int lat = 0;
    slv_wait = 3;
    slv_use_addr = 0;
    slv_rdata = 32'hBAD0BAD0;
    @(negedge PCLK);
    issue(2, 1'b1, 32'h80, 32'h12345678, 1);
    push_exp(2, 32'h0, 1'b0);
    while (lat < 20) begin
      @(posedge PCLK);
      #1;
      lat++;
      if (s_pready[2]) break;
    end
    n_checks++;
    if (lat !== 6) begin
      n_fail++;
      $display("FAIL wr_latency: s_pready[2] after %0d cycles required 6", lat);
    end
    @(negedge PCLK);
    #1;
    s_psel[2] = 1'b0;
    s_penable[2] = 1'b0;
    req_left[2] = 0;
    @(posedge PCLK);
    #1;
    n_checks++;
    if (s_pready !== '0) begin
      n_fail++;
      $display("FAIL wr_pulse_width: s_pready=%b one cycle later required 0000", s_pready);
    end
    n_checks++;
    if (!stable || first_addr !== 32'h80 || first_wdata !== 32'h12345678 || first_write !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_payload: stable=%0d addr=%h wdata=%h write=%b required 1 00000080 12345678 1",
               stable, first_addr, first_wdata, first_write);
    end
    wait_drain(20);
  endtask

  task automatic test_timeout();
    slv_hang = 1;
    slv_rdata = 32'h5A5A5A5A;
    acc_total = 0;
    @(negedge PCLK);
    issue(3, 1'b0, 32'hC0, 32'h0, 1);
    push_exp(3, 32'h0, 1'b1);
    wait_drain(60);
    n_checks++;
    if (acc_total !== TIMEOUT) begin
      n_fail++;
      $display("FAIL timeout_len: ACCESS lasted %0d cycles required %0d", acc_total, TIMEOUT);
    end
    slv_hang = 0;
  endtask

  task automatic test_contention();
    int left[NREQ];
    int p;
    slv_wait = 1;
    slv_use_addr = 1;
    slv_err = 0;
    @(negedge PCLK);
    for (int i = 0; i < NREQ; i++) begin
      issue(i, 1'b0, 32'h100 + 32'(4 * i), 32'h0, 2);
      left[i] = 2;
    end
    for (int n = 0; n < 2 * NREQ; n++) begin
      p = m_ptr;
      while (left[p] == 0) p = (p + 1) % NREQ;
      left[p]--;
      push_exp(p, (32'h100 + 32'(4 * p)) ^ 32'hCAFE0000, 1'b0);
    end
    wait_drain(200);
    n_checks++;
    if (grant_id !== 2'd3) begin
      n_fail++;
      $display("FAIL contention_last: grant_id=%0d required 3", grant_id);
    end
    slv_wait = 0;
    slv_use_addr = 0;
  endtask

  task automatic test_slave_error();
    slv_rdata = 32'h0000FFFF;
    slv_err = 1;
    slv_wait = 0;
    @(negedge PCLK);
    issue(0, 1'b0, 32'h10, 32'h0, 1);
    push_exp(0, 32'h0000FFFF, 1'b1);
    wait_drain(20);
    slv_err = 0;
  endtask

  task automatic test_reset_mid();
    int k = 0;
    slv_wait = 6;
    slv_rdata = 32'h1;
    @(negedge PCLK);
    issue(2, 1'b0, 32'h20, 32'h0, 1);
    push_exp(2, 32'h1, 1'b0);
    while (!(m_psel && m_penable) && k < 10) begin
      @(posedge PCLK);
      #1;
      k++;
    end
    n_checks++;
    if (!(m_psel && m_penable)) begin
      n_fail++;
      $display("FAIL rst_reach_access: no ACCESS after %0d cycles", k);
    end
    @(posedge PCLK);
    #3;
    PRESETn = 1'b0;
    #1;
    n_checks++;
    if (m_psel !== 1'b0 || m_penable !== 1'b0 || s_pready !== '0) begin
      n_fail++;
      $display("FAIL rst_async: psel=%b penable=%b s_pready=%b required 0 0 0000",
               m_psel, m_penable, s_pready);
    end
    sb.delete();
    s_psel = '0;
    s_penable = '0;
    for (int i = 0; i < NREQ; i++) req_left[i] = 0;
    m_ptr = 0;
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;
    slv_wait = 0;
    slv_use_addr = 1;
    issue(1, 1'b0, 32'h24, 32'h0, 1);
    issue(3, 1'b0, 32'h2C, 32'h0, 1);
    push_exp(1, 32'h24 ^ 32'hCAFE0000, 1'b0);
    push_exp(3, 32'h2C ^ 32'hCAFE0000, 1'b0);
    @(posedge PCLK);
    #1;
    n_checks++;
    if (grant_id !== 2'd1) begin
      n_fail++;
      $display("FAIL rst_rr_restart: first grant %0d required 1", grant_id);
    end
    wait_drain(40);
    slv_use_addr = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NREQ; i++) req_left[i] = 0;
    test_reset();
    test_single_read();
    test_write_waits();
    test_timeout();
    test_contention();
    test_slave_error();
    test_reset_mid();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: %0d expected responses never seen", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/apb_fabric_arbiter.md
Name: apb_fabric_arbiter

Overview:
- N-to-1 APB arbiter for the APB fabric: N upstream APB requesters (DMA cores, debug, CPU bridge) share one downstream APB segment.
- Round-robin grant; registered downstream SETUP/ACCESS sequencing; per-transfer PREADY timeout with forced error response.
- Address/data widths come from the fabric parameter package (project-wide PADDR/PDATA).

Parameters:
- NREQ, 4, number of upstream requesters (2..16)
- PADDR, apb_fabric_verif_param_pkg::PADDR, address width
- PDATA, apb_fabric_verif_param_pkg::PDATA, data width
- TIMEOUT, 256, max ACCESS cycles waiting for m_pready; 0 disables timeout

Ports:
- PCLK  in  1  fabric clock
- PRESETn  in  1  asynchronous active-low reset
- s_psel  in  NREQ  per-requester PSEL
- s_penable  in  NREQ  per-requester PENABLE
- s_pwrite  in  NREQ  per-requester PWRITE
- s_paddr  in  NREQ*PADDR  packed addresses, requester i at [i*PADDR +: PADDR]
- s_pwdata  in  NREQ*PDATA  packed write data
- s_prdata  out  PDATA  shared read data, valid only with the s_pready bit
- s_pready  out  NREQ  one-hot completion
- s_pslverr  out  NREQ  error, valid with s_pready
- m_psel, m_penable, m_pwrite  out  1  downstream control
- m_paddr  out  PADDR  downstream address
- m_pwdata  out  PDATA  downstream write data
- m_prdata  in  PDATA  downstream read data
- m_pready  in  1  downstream ready
- m_pslverr  in  1  downstream error
- grant_id  out  clog2(NREQ)  index of the current or last granted requester (debug)

Behaviour:
- Clock and reset: one clock, PCLK. Reset PRESETn is asynchronous, active-low.
- Reset values: all outputs 0; FSM=IDLE; rr_ptr=0; timeout counter=0.
- FSM states: IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
- IDLE: if any s_psel is set, pick the winner by round-robin:
  - search starts at rr_ptr and wraps modulo NREQ;
  - capture the winner's pwrite/paddr/pwdata into registers;
  - grant_id <= winner; rr_ptr <= winner+1 (wrap to 0 at NREQ);
  - go to SETUP. No request: stay in IDLE, outputs 0.
- SETUP (1 cycle): m_psel=1, m_penable=0, m_* driven from captured registers; go to ACCESS.
- ACCESS: m_psel=1, m_penable=1. Address, write and data stay stable until exit.
  - m_pready=1: capture m_prdata (reads only; writes capture 0) and m_pslverr; go to RESP.
  - TIMEOUT!=0 and the counter reaches TIMEOUT-1 without m_pready: drop m_psel/m_penable next cycle; return s_prdata=0, pslverr=1; go to RESP.
  - The counter clears on ACCESS entry.
- RESP (1 cycle): s_pready[grant_id]=1, s_pslverr[grant_id]=captured error, s_prdata=captured data. All other s_pready bits 0. Then go to IDLE.
- Latency: requester PSEL seen in IDLE at cycle T.
  - Downstream SETUP at T+1, ACCESS from T+2.
  - Zero-wait slave: s_pready at T+3. Minimum 4 cycles per transfer; no back-to-back overlap.
- Upstream rules:
  - Requesters obey APB: PSEL held and payload stable until s_pready.
  - s_penable is not used for arbitration.
  - A requester that drops PSEL before completion is a protocol violation. The transfer still completes downstream and the s_pready pulse is discarded by the requester.
- Simultaneous requests: exactly one grant per IDLE cycle. A requester that has just been served has the lowest priority next round. With all NREQ requesting continuously, grants rotate 0,1,..,NREQ-1,0.
- m_pready asserted outside ACCESS is ignored.
- The timeout check and m_pready are evaluated in the same cycle; m_pready wins (normal completion).
- Reset mid-transfer: all outputs deassert asynchronously; no response is generated for the in-flight transfer; rr_ptr returns to 0.
- Widths: the timeout counter is clog2(TIMEOUT+1) bits and saturates; it does not wrap.

Test Plan:
- Single read, zero wait:
  - Stimulus: req1 reads 0x40, m_prdata=0xDEADBEEF, m_pready tied 1.
  - Response: m_psel rises at T+1, m_penable at T+2; s_pready=4'b0010 at T+3; s_prdata=0xDEADBEEF; pslverr=0.
- Write with waits:
  - Stimulus: req2 writes 0x1234_5678 to 0x80; slave inserts 3 wait states.
  - Response: m_paddr/m_pwdata stable through ACCESS; s_pready[2] pulses exactly 1 cycle, at T+6.
- Full contention:
  - Stimulus: all 4 requesters request continuously for 8 transfers.
  - Response: grant_id sequence 0,1,2,3,0,1,2,3; no s_pready bit asserted for a non-granted requester.
- Timeout:
  - Stimulus: TIMEOUT=8, m_pready held 0.
  - Response: ACCESS lasts 8 cycles; m_psel drops; s_pslverr[granted]=1 and s_prdata=0 in RESP.
- Slave error:
  - Stimulus: req0 read; m_pready=1 with m_pslverr=1, m_prdata=0xFFFF.
  - Response: s_pslverr[0]=1, s_prdata=0xFFFF.
- Reset mid-ACCESS:
  - Stimulus: assert PRESETn=0 during a wait state.
  - Response: m_psel, m_penable and s_pready go 0 immediately. After release, the next grant starts from requester 0.
